ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the 5-stage 32-bit MIPS-style pipeline; sits between the ID/EX and EX/MEM latches.
//  - Latches IR, A and B on the falling clock edge.
//  - Decodes the latched instruction into an ALU op.
//  - Computes the ALU result with zero and overflow flags.
//  - Evaluates the branch-zero condition.
//  - Contains instruction analyser, ALU controller and 32-bit ALU.
// PARAMETERS
//  none (datapath fixed at 32 bits)
// PORTS
//  clk   in   1   pipeline clock; internal regs capture on falling edge
//  rst   in   1   reset, asynchronous, active-low
//  IRi   in   32  instruction from ID stage
//  NPCi  in   32  next PC (PC+4) from ID stage
//  Ai    in   32  rs operand
//  Bi    in   32  rt operand
//  Immi  in   32  sign-extended immediate
//  cond  out  1   branch condition, combinational: 1 iff Ai==0
//  ALUo  out  32  ALU result from latched A,B
//  ZFo   out  1   1 iff ALUo==0
//  OFo   out  1   signed overflow (ADD/SUB only, else 0)
//  Bo    out  32  latched B (store data / operand)
//  IRo   out  32  latched IR, forwarded to MEM
// BEHAVIOUR
//  Decode (IR[31:26]=opcode, IR[5:0]=funct):
//  - isALUR: opcode==6'h00.
//  - isBranch: opcode==6'h04 (beq) or 6'h05 (bne).
//  ALU_OP (3 bits):
//  - Codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOR, 110 SLT (signed), 111 SLTU.
//  - R-type funct: 20/21→ADD, 22/23→SUB, 24→AND, 25→OR, 26→XOR, 27→NOR, 2A→SLT, 2B→SLTU.
//  - I-type opcode: 08/09→ADD, 0A→SLT, 0B→SLTU, 0C→AND, 0D→OR, 0E→XOR, 23/2B (lw/sw)→ADD.
//  - Branch: 04/05→ADD.
//  - Any unlisted opcode or funct→ADD.
//  Registers:
//  - rst low (async): IR=A=B=0 immediately, regardless of clk.
//  - Falling edge of clk with rst high: IR<=IRi. The A and B selections are decoded from IRi, the instruction being captured:
//    - A <= isBranch ? NPCi : Ai.
//    - B <= isALUR ? Bi : isBranch ? (Immi<<2) : Immi. The shift is logical, 32-bit, upper bits dropped.
//  Combinational outputs:
//  - ALUo/ZFo/OFo are pure functions of latched A,B and the ALU_OP decoded from latched IR. Valid same half-cycle after the falling edge.
//  - Latency IRi→ALUo: one falling edge.
//  - cond depends only on the Ai input (unlatched) and has zero latency.
//  ALU arithmetic:
//  - ADD/SUB are 32-bit wrap-around.
//  - OF=1 when ADD operands share a sign and the result sign differs.
//  - SUB: OF=1 when the operand signs differ and the result sign differs from A.
//  - SLT/SLTU: result is 32'd1 or 32'd0.
//  Reset state (IR=0 decodes as R-type funct 00, i.e. ADD): ALUo=0, ZFo=1, OFo=0, Bo=0, IRo=0.
//  - Reset released between edges: regs hold 0 until the next falling edge.
//  - Rising edges never change state.
// TESTING
//  1. R-type add:
//     - Stimulus: IRi=0x00221820, Ai=5, Bi=7, falling edge.
//     - Response: ALUo=12, ZFo=0, OFo=0, Bo=7, IRo=0x00221820.
//  2. Sub overflow:
//     - Stimulus: IRi=0x00221822, Ai=0x80000000, Bi=1.
//     - Response: ALUo=0x7FFFFFFF, OFo=1. Same with Ai=Bi=9 → ALUo=0, ZFo=1, OFo=0.
//  3. addi:
//     - Stimulus: IRi=0x20230004, Ai=10, Bi=99, Immi=0xFFFFFFFC.
//     - Response: ALUo=6, Bo=0xFFFFFFFC. Bi is ignored.
//  4. beq:
//     - Stimulus: IRi=0x10200003, NPCi=0x100, Immi=3, Ai=0.
//     - Response: cond=1 before the edge; after the edge ALUo=0x10C. With Ai=4, cond=0.
//  5. SLT vs SLTU:
//     - Stimulus: Ai=0xFFFFFFFF, Bi=1, funct 2A, then funct 2B.
//     - Response: funct 2A → ALUo=1; funct 2B → ALUo=0, ZFo=1.
//  6. Mid-operation reset:
//     - Stimulus: after test 1, pull rst low between clock edges.
//     - Response: IRo=0, Bo=0, ALUo=0, ZFo=1 immediately. No capture while rst is low.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of the 32-bit MIPS-style pipeline. Captures IR/A/B on the falling edge
// and computes the ALU result, zero and signed-overflow flags from the captured operands.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IRi,
  input  logic [31:0] NPCi,
  input  logic [31:0] Ai,
  input  logic [31:0] Bi,
  input  logic [31:0] Immi,
  output logic        cond,
  output logic [31:0] ALUo,
  output logic        ZFo,
  output logic        OFo,
  output logic [31:0] Bo,
  output logic [31:0] IRo
);

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_NOR  = 3'b101,
    ALU_SLT  = 3'b110,
    ALU_SLTU = 3'b111
  } alu_op_t;

  logic [DATA_W-1:0]        ir_p0;
  logic signed [DATA_W-1:0] a_p0;
  logic signed [DATA_W-1:0] b_p0;
  logic signed [DATA_W-1:0] b_sel;
  logic signed [DATA_W-1:0] a_sel;
  alu_op_t                  op;
  logic [DATA_W:0]          alu_res;

  function automatic logic is_alur(input logic [5:0] opcode);
    return opcode == 6'h00;
  endfunction

  function automatic logic is_branch(input logic [5:0] opcode);
    return (opcode == 6'h04) || (opcode == 6'h05);
  endfunction

  // Anything not recognised falls back to ADD so unknown encodings stay harmless.
  function automatic alu_op_t decode_op(input logic [5:0] opcode, input logic [5:0] funct);
    alu_op_t r;
    r = ALU_ADD;
    if (opcode == 6'h00) begin
      case (funct)
        6'h20, 6'h21: r = ALU_ADD;
        6'h22, 6'h23: r = ALU_SUB;
        6'h24:        r = ALU_AND;
        6'h25:        r = ALU_OR;
        6'h26:        r = ALU_XOR;
        6'h27:        r = ALU_NOR;
        6'h2A:        r = ALU_SLT;
        6'h2B:        r = ALU_SLTU;
        default:      r = ALU_ADD;
      endcase
    end else begin
      case (opcode)
        6'h08, 6'h09: r = ALU_ADD;
        6'h0A:        r = ALU_SLT;
        6'h0B:        r = ALU_SLTU;
        6'h0C:        r = ALU_AND;
        6'h0D:        r = ALU_OR;
        6'h0E:        r = ALU_XOR;
        default:      r = ALU_ADD;
      endcase
    end
    return r;
  endfunction

  // Returns {overflow, result}; overflow is only meaningful for ADD and SUB.
  function automatic logic [DATA_W:0] alu_calc(input alu_op_t f_op,
                                               input logic signed [DATA_W-1:0] a,
                                               input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] r;
    logic                     of;
    r  = '0;
    of = 1'b0;
    case (f_op)
      ALU_ADD: begin
        r  = a + b;
        of = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        r  = a - b;
        of = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_SLTU: r = {{(DATA_W-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
      default:  r = a + b;
    endcase
    return {of, r};
  endfunction

  // Operand selection is steered by the instruction being captured, not the latched one.
  always_comb begin
    a_sel = $signed(Ai);
    b_sel = $signed(Immi);
    if (is_branch(IRi[31:26])) begin
      a_sel = $signed(NPCi);
      b_sel = $signed({Immi[DATA_W-3:0], 2'b00});
    end else if (is_alur(IRi[31:26])) begin
      b_sel = $signed(Bi);
    end
  end

  // Stage p0: falling-edge ID/EX capture
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      ir_p0 <= '0;
      a_p0  <= '0;
      b_p0  <= '0;
    end else begin
      ir_p0 <= IRi;
      a_p0  <= a_sel;
      b_p0  <= b_sel;
    end
  end

  assign op      = decode_op(ir_p0[31:26], ir_p0[5:0]);
  assign alu_res = alu_calc(op, a_p0, b_p0);

  assign ALUo = alu_res[DATA_W-1:0];
  assign OFo  = alu_res[DATA_W];
  assign ZFo  = (alu_res[DATA_W-1:0] == '0);
  assign Bo   = b_p0;
  assign IRo  = ir_p0;
  assign cond = (Ai == '0);

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: literal expectations per vector plus a per-cycle
// comparison against an arithmetic reference model of the execute stage.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] IRi = '0, NPCi = '0, Ai = '0, Bi = '0, Immi = '0;
  logic        cond, ZFo, OFo;
  logic [31:0] ALUo, Bo, IRo;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  logic [31:0] m_ir = '0, m_a = '0, m_b = '0;

  ex_stage dut (
    .clk (clk), .rst (rst), .IRi (IRi), .NPCi (NPCi), .Ai (Ai), .Bi (Bi), .Immi (Immi),
    .cond (cond), .ALUo (ALUo), .ZFo (ZFo), .OFo (OFo), .Bo (Bo), .IRo (IRo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the execute stage must produce for a captured instruction.
  function automatic void model_alu(input logic [31:0] ir, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic of);
    logic [5:0] opc;
    logic [5:0] fn;
    longint     sa, sb, w;
    string      k;
    opc = ir[31:26];
    fn  = ir[5:0];
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    k   = "add";
    if (opc == 6'h00) begin
      if (fn == 6'h22 || fn == 6'h23) k = "sub";
      else if (fn == 6'h24) k = "and";
      else if (fn == 6'h25) k = "or";
      else if (fn == 6'h26) k = "xor";
      else if (fn == 6'h27) k = "nor";
      else if (fn == 6'h2A) k = "slt";
      else if (fn == 6'h2B) k = "sltu";
    end else if (opc == 6'h0A) k = "slt";
    else if (opc == 6'h0B) k = "sltu";
    else if (opc == 6'h0C) k = "and";
    else if (opc == 6'h0D) k = "or";
    else if (opc == 6'h0E) k = "xor";
    of = 1'b0;
    w  = 0;
    if (k == "add" || k == "sub") begin
      w  = (k == "add") ? sa + sb : sa - sb;
      r  = w[31:0];
      of = (w > 64'sd2147483647) || (w < -64'sd2147483648);
    end else if (k == "and") r = a & b;
    else if (k == "or")   r = a | b;
    else if (k == "xor")  r = a ^ b;
    else if (k == "nor")  r = ~(a | b);
    else if (k == "slt")  r = (sa < sb) ? 32'd1 : 32'd0;
    else                  r = (a < b) ? 32'd1 : 32'd0;
  endfunction

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      m_ir = '0; m_a = '0; m_b = '0;
    end else begin
      m_ir = IRi;
      m_a  = (IRi[31:26] == 6'h04 || IRi[31:26] == 6'h05) ? NPCi : Ai;
      if (IRi[31:26] == 6'h00)                                 m_b = Bi;
      else if (IRi[31:26] == 6'h04 || IRi[31:26] == 6'h05)     m_b = Immi * 4;
      else                                                     m_b = Immi;
    end
  end

  always @(posedge clk) begin
    logic [31:0] er;
    logic        eof;
    if (cmp_en) begin
      model_alu(m_ir, m_a, m_b, er, eof);
      chk("model ALUo", ALUo, er);
      chk("model OFo", {31'b0, OFo}, {31'b0, eof});
      chk("model ZFo", {31'b0, ZFo}, {31'b0, er == 32'd0});
      chk("model Bo", Bo, m_b);
      chk("model IRo", IRo, m_ir);
      chk("model cond", {31'b0, cond}, {31'b0, Ai == 32'd0});
    end
  end

  task automatic drive(input logic [31:0] ir, input logic [31:0] npc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm);
    @(posedge clk);
    #1;
    IRi = ir; NPCi = npc; Ai = a; Bi = b; Immi = imm;
  endtask

  task automatic step(input logic [31:0] ir, input logic [31:0] npc, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] imm);
    drive(ir, npc, a, b, imm);
    @(negedge clk);
    #2;
  endtask

  initial begin
    #0 rst = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    cmp_en = 1'b1;
    chk("rst ALUo", ALUo, 32'd0);
    chk("rst ZFo", {31'b0, ZFo}, 32'd1);
    chk("rst OFo", {31'b0, OFo}, 32'd0);
    chk("rst Bo", Bo, 32'd0);
    chk("rst IRo", IRo, 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    step(32'h00221820, 32'h0, 32'd5, 32'd7, 32'h0);
    chk("add ALUo", ALUo, 32'd12);
    chk("add ZFo", {31'b0, ZFo}, 32'd0);
    chk("add OFo", {31'b0, OFo}, 32'd0);
    chk("add Bo", Bo, 32'd7);
    chk("add IRo", IRo, 32'h00221820);

    step(32'h00221822, 32'h0, 32'h80000000, 32'd1, 32'h0);
    chk("sub ovf ALUo", ALUo, 32'h7FFFFFFF);
    chk("sub ovf OFo", {31'b0, OFo}, 32'd1);
    step(32'h00221822, 32'h0, 32'd9, 32'd9, 32'h0);
    chk("sub zero ALUo", ALUo, 32'd0);
    chk("sub zero ZFo", {31'b0, ZFo}, 32'd1);
    chk("sub zero OFo", {31'b0, OFo}, 32'd0);

    step(32'h00221820, 32'h0, 32'h7FFFFFFF, 32'd1, 32'h0);
    chk("add ovf ALUo", ALUo, 32'h80000000);
    chk("add ovf OFo", {31'b0, OFo}, 32'd1);

    step(32'h20230004, 32'h0, 32'd10, 32'd99, 32'hFFFFFFFC);
    chk("addi ALUo", ALUo, 32'd6);
    chk("addi Bo", Bo, 32'hFFFFFFFC);

    drive(32'h10200003, 32'h100, 32'd0, 32'd55, 32'd3);
    #1 chk("beq cond1", {31'b0, cond}, 32'd1);
    @(negedge clk); #2;
    chk("beq ALUo", ALUo, 32'h10C);
    chk("beq Bo", Bo, 32'd12);
    Ai = 32'd4;
    #1 chk("beq cond0", {31'b0, cond}, 32'd0);

    step(32'h0022182A, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0);
    chk("slt ALUo", ALUo, 32'd1);
    step(32'h0022182B, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0);
    chk("sltu ALUo", ALUo, 32'd0);
    chk("sltu ZFo", {31'b0, ZFo}, 32'd1);

    step(32'h00221827, 32'h0, 32'h0F0F0000, 32'h000000FF, 32'h0);
    chk("nor ALUo", ALUo, 32'hF0F0FF00);
    step(32'h34230000, 32'h0, 32'h12340000, 32'h0, 32'h00005678);
    chk("ori ALUo", ALUo, 32'h12345678);
    step(32'hAC230010, 32'h0, 32'h1000, 32'd42, 32'h10);
    chk("sw ALUo", ALUo, 32'h1010);
    step(32'hFC000000, 32'h0, 32'd3, 32'd9, 32'd4);
    chk("unlisted ALUo", ALUo, 32'd7);
    step(32'h2823FFFF, 32'h0, 32'h80000000, 32'd0, 32'h7FFFFFFF);
    chk("slti ALUo", ALUo, 32'd1);
    chk("slti OFo", {31'b0, OFo}, 32'd0);

    step(32'h00221820, 32'h0, 32'd5, 32'd7, 32'h0);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("mrst IRo", IRo, 32'd0);
    chk("mrst Bo", Bo, 32'd0);
    chk("mrst ALUo", ALUo, 32'd0);
    chk("mrst ZFo", {31'b0, ZFo}, 32'd1);
    IRi = 32'h00221825; Ai = 32'd1; Bi = 32'd2;
    @(negedge clk); #2;
    chk("mrst hold IRo", IRo, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    #1 chk("rel hold IRo", IRo, 32'd0);
    @(negedge clk); #2;
    chk("rel cap IRo", IRo, 32'h00221825);
    chk("rel cap ALUo", ALUo, 32'd3);

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
